fetch_queue: RTL and testbench

//  Instruction prefetch stage directly upstream of the pipelined datapath's IF stage. Issues in-order

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_fifo.sv | 43 ++++
 rtl/fetch_queue.sv | 76 +++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and the buffered fetch entry layout for the prefetch queue.
package fetch_queue_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int FETCH_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: synchronous {pc,instr} FIFO with combinational head read; flush empties it and beats push.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [63:0]             wrData,
  output logic [63:0]             rdData,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic doPush, doPop;
  assign doPop = pop && (count != '0) && !flush;
  // a full queue can still take a word when the head leaves in the same cycle
  assign doPush = push && !flush && ((count != CW'(DEPTH)) || doPop);
  assign rdData = mem[rdPtr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetch with credit-limited issue and redirect flush of the queue
// and of every word still in flight on the abandoned path.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        RedirectD,
  input  logic [31:0] RedirectPC,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        ValidF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fpc, respPc;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW:0] inFlight;
  logic issue, keep, pop;
  logic [63:0] headRaw;
  fetchEntry_t head;
  fetchEntry_t pushEntry;
  // buffered plus requested words never exceed the queue, so every kept response has a slot
  assign inFlight = {1'b0, count} + {1'b0, outstanding};
  assign imem_req = reset && !RedirectD && (inFlight < (CW+1)'(DEPTH));
  assign imem_addr = fpc;
  assign issue = imem_req && imem_gnt;
  assign keep = imem_rvalid && (discard == '0) && !RedirectD;
  assign pop = ValidF && !StallF;
  assign ValidF = count != '0;
  assign head = fetchEntry_t'(headRaw);
  assign InstrF = ValidF ? head.instr : NOP_INSTR;
  assign PCF = ValidF ? head.pc : '0;
  assign pushEntry = '{pc: respPc, instr: imem_rdata};
  fetch_fifo #(.DEPTH(DEPTH)) fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (keep),
    .pop    (pop),
    .flush  (RedirectD),
    .wrData (pushEntry),
    .rdData (headRaw),
    .count  (count)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (RedirectD) begin
      fpc         <= RedirectPC;
      respPc      <= RedirectPC;
      outstanding <= outstanding - CW'(imem_rvalid);
      // every word still in flight belongs to a dead path; the ones already marked are among them
      discard     <= outstanding - CW'(imem_rvalid);
    end else begin
      if (issue) fpc <= nextPc(fpc);
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      if (keep) respPc <= nextPc(respPc);
    end
  end
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid && (outstanding == '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
    inFlight <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios against a latency-programmable memory model; a monitor
// scores every consumed head against the expected PC stream queued by the stimulus.
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic StallF = 0;
  logic RedirectD = 0;
  logic [31:0] RedirectPC = '0;
  logic [31:0] InstrF, PCF, imem_addr;
  logic ValidF, imem_req;
  logic imem_gnt = 1;
  logic imem_rvalid = 0;
  logic [31:0] imem_rdata = '0;
  int checks = 0;
  int failures = 0;
  int pops = 0;
  int lat = 1;
  int cyc = 0;
  logic [31:0] expq[$];
  logic [31:0] pendA[$];
  int pendD[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_queue dut (
    .clk(clk), .reset(reset), .StallF(StallF), .RedirectD(RedirectD), .RedirectPC(RedirectPC),
    .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int l, input logic [31:0] base);
    reset = 0;
    StallF = 0;
    RedirectD = 0;
    lat = l;
    expq.delete();
    for (int i = 0; i < 40; i++) expq.push_back(base + 32'(4 * i));
    pops = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic waitPops(input string name, input int n);
    int w = 0;
    while (pops < n && w < 60) begin
      nextCycle();
      w++;
    end
    checkBit(name, pops >= n, 1'b1);
  endtask

  // memory: responses in issue order, lat cycles after the grant cycle; wiped by reset
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      pendA.delete();
      pendD.delete();
      imem_rvalid = 0;
    end else begin
      if (imem_rvalid) begin
        void'(pendA.pop_front());
        void'(pendD.pop_front());
      end
      if (imem_req && imem_gnt) begin
        pendA.push_back(imem_addr);
        pendD.push_back(cyc + lat);
      end
      if (pendD.size() > 0 && pendD[0] <= cyc) begin
        imem_rvalid = 1;
        imem_rdata = word(pendA[0]);
      end else begin
        imem_rvalid = 0;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset && ValidF && !StallF && !RedirectD) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL head pc got=%h exp=<none>", PCF);
        end else begin
          e = expq.pop_front();
          check("head pc", PCF, e);
          check("head instr", InstrF, word(e));
        end
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 0;
    #1;
    checkBit("rst ValidF", ValidF, 1'b0);
    check("rst InstrF", InstrF, NOP_INSTR);
    check("rst PCF", PCF, 32'h0);
    checkBit("rst req", imem_req, 1'b0);
    // sequential stream, one word per cycle
    doReset(1, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (k == 1) begin
        checkBit("t1 req", imem_req, 1'b1);
        check("t1 addr0", imem_addr, 32'h0);
      end
      if (k == 2) check("t1 addr1", imem_addr, 32'h4);
      checkBit("t1 valid", ValidF, k >= 3);
      nextCycle();
    end
    check("t1 pops", 32'(pops), 32'd10);
    // stall fills the queue, then drains without gap
    doReset(1, 32'h0);
    for (int w = 0; w < 20 && !(ValidF && PCF == 32'h10); w++) nextCycle();
    check("t2 head 0x10", PCF, 32'h10);
    StallF = 1;
    repeat (10) nextCycle();
    #1;
    checkBit("t2 stall valid", ValidF, 1'b1);
    check("t2 stall pc", PCF, 32'h10);
    check("t2 stall instr", InstrF, word(32'h10));
    checkBit("t2 full req", imem_req, 1'b0);
    check("t2 pops pre", 32'(pops), 32'd4);
    StallF = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checkBit("t2 no gap", ValidF, 1'b1);
      nextCycle();
    end
    check("t2 pops post", 32'(pops), 32'd14);
    // redirect with three requests in flight
    doReset(5, 32'h400);
    #1;
    checkBit("t3 req c1", imem_req, 1'b1);
    nextCycle();
    nextCycle();
    #1;
    check("t3 addr c3", imem_addr, 32'h8);
    nextCycle();
    RedirectD = 1;
    RedirectPC = 32'h400;
    #1;
    checkBit("t3 req redirect", imem_req, 1'b0);
    nextCycle();
    RedirectD = 0;
    #1;
    checkBit("t3 req c5", imem_req, 1'b1);
    check("t3 addr c5", imem_addr, 32'h400);
    for (int k = 5; k <= 10; k++) begin
      checkBit("t3 dropped", ValidF, 1'b0);
      nextCycle();
    end
    checkBit("t3 first kept", ValidF, 1'b1);
    waitPops("t3 stream", 6);
    // redirect in the same cycle as a response
    doReset(2, 32'h800);
    nextCycle();
    nextCycle();
    RedirectD = 1;
    RedirectPC = 32'h800;
    #1;
    checkBit("t4 req redirect", imem_req, 1'b0);
    nextCycle();
    RedirectD = 0;
    #1;
    check("t4 addr", imem_addr, 32'h800);
    for (int k = 4; k <= 6; k++) begin
      checkBit("t4 dropped", ValidF, 1'b0);
      nextCycle();
    end
    checkBit("t4 first kept", ValidF, 1'b1);
    waitPops("t4 stream", 4);
    // back-to-back redirects
    doReset(4, 32'h200);
    nextCycle();
    nextCycle();
    RedirectD = 1;
    RedirectPC = 32'h100;
    nextCycle();
    RedirectD = 0;
    #1;
    check("t5 addr 0x100", imem_addr, 32'h100);
    nextCycle();
    RedirectD = 1;
    RedirectPC = 32'h200;
    nextCycle();
    RedirectD = 0;
    #1;
    check("t5 addr 0x200", imem_addr, 32'h200);
    for (int k = 6; k <= 10; k++) begin
      checkBit("t5 dropped", ValidF, 1'b0);
      nextCycle();
    end
    checkBit("t5 first kept", ValidF, 1'b1);
    waitPops("t5 stream", 6);
    // reset mid-stream with words buffered and in flight
    doReset(3, 32'h0);
    StallF = 1;
    repeat (5) nextCycle();
    checkBit("t6 buffered", ValidF, 1'b1);
    reset = 0;
    #1;
    checkBit("t6 rst ValidF", ValidF, 1'b0);
    check("t6 rst PCF", PCF, 32'h0);
    check("t6 rst InstrF", InstrF, NOP_INSTR);
    checkBit("t6 rst req", imem_req, 1'b0);
    doReset(1, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (k == 1) check("t6 restart addr", imem_addr, 32'h0);
      checkBit("t6 valid", ValidF, k >= 3);
      nextCycle();
    end
    check("t6 pops", 32'(pops), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
